// File: rtl/load_use_scoreboard_pkg.sv
// load_use_scoreboard_pkg: shared types, widths and the free-slot priority encoder.
package load_use_scoreboard_pkg;
  localparam int DEF_REG_W = 5;
  localparam int DEF_TAG_W = 2;
  localparam int MAX_REG_W = 8;
  localparam int LAT_W = 8;
  typedef struct packed {
    logic                 valid;
    logic [MAX_REG_W-1:0] rd;
    logic [LAT_W-1:0]     cnt;
  } sb_entry_t;
  function automatic int first_free(input logic [31:0] busy);
    first_free = 32;
    for (int i = 31; i >= 0; i--) if (!busy[i]) first_free = i;
  endfunction
endpackage

// File: rtl/load_use_scoreboard_if.sv
// load_use_scoreboard_if: ID-stage, completion and stall-control signals of the scoreboard.
interface load_use_scoreboard_if
  import load_use_scoreboard_pkg::*;
#(
  parameter int REG_W = DEF_REG_W,
  parameter int TAG_W = DEF_TAG_W,
  parameter int CNT_W = 32
);
  logic             inIdValid;
  logic [REG_W-1:0] inIdRs1;
  logic [REG_W-1:0] inIdRs2;
  logic             inIdUsesRs1;
  logic             inIdUsesRs2;
  logic             inIdIsLoad;
  logic [REG_W-1:0] inIdRd;
  logic             inCplValid;
  logic [TAG_W-1:0] inCplTag;
  logic [TAG_W-1:0] outAllocTag;
  logic             outPCWrite;
  logic             outIfIdWrite;
  logic             outCtrlMux;
  logic             outFull;
  logic [CNT_W-1:0] outStallCount;
  modport master (
    output inIdValid, inIdRs1, inIdRs2, inIdUsesRs1, inIdUsesRs2, inIdIsLoad, inIdRd, inCplValid, inCplTag,
    input  outAllocTag, outPCWrite, outIfIdWrite, outCtrlMux, outFull, outStallCount
  );
  modport slave (
    input  inIdValid, inIdRs1, inIdRs2, inIdUsesRs1, inIdUsesRs2, inIdIsLoad, inIdRd, inCplValid, inCplTag,
    output outAllocTag, outPCWrite, outIfIdWrite, outCtrlMux, outFull, outStallCount
  );
endinterface

// File: rtl/load_use_scoreboard_slot.sv
// load_use_scoreboard_slot: one in-flight load entry with allocate, completion and countdown.
module load_use_scoreboard_slot
  import load_use_scoreboard_pkg::*;
#(
  parameter int LOAD_LAT = 1,
  parameter int VAR_LAT  = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 alloc,
  input  logic [MAX_REG_W-1:0] allocRd,
  input  logic                 cpl,
  output logic                 valid,
  output logic [MAX_REG_W-1:0] rd
);
  sb_entry_t entry;
  logic expire;
  assign expire = (VAR_LAT != 0) ? cpl : entry.cnt == LAT_W'(1);
  // allocation is checked before expiry so a same-edge reuse keeps the new load
  always_ff @(posedge clk) begin
    if (reset) entry <= '0;
    else if (alloc) entry <= '{valid: 1'b1, rd: allocRd, cnt: LAT_W'(LOAD_LAT)};
    else if (entry.valid && expire) entry <= '0;
    else if (entry.valid && VAR_LAT == 0) entry.cnt <= entry.cnt - 1'b1;
  end
  assign valid = entry.valid;
  assign rd = entry.rd;
endmodule

// File: rtl/load_use_scoreboard.sv
// load_use_scoreboard: tracks in-flight loads by destination and stalls ID on a load-use hazard.
module load_use_scoreboard
  import load_use_scoreboard_pkg::*;
#(
  parameter int NUM_SLOTS = 4,
  parameter int REG_W     = DEF_REG_W,
  parameter int LOAD_LAT  = 1,
  parameter int VAR_LAT   = 0,
  parameter int TAG_W     = $clog2(NUM_SLOTS),
  parameter int CNT_W     = 32
) (
  input logic clk,
  input logic reset,
  load_use_scoreboard_if.slave sb
);
  logic [NUM_SLOTS-1:0] slotValid, hit1, hit2, allocVec, cplVec;
  logic [MAX_REG_W-1:0] slotRd [NUM_SLOTS];
  logic hazard, full, stall, allocEn;
  logic [TAG_W-1:0] allocTag;
  logic [CNT_W-1:0] stallCount;
  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    assign hit1[i] = slotValid[i] && slotRd[i] == MAX_REG_W'(sb.inIdRs1);
    assign hit2[i] = slotValid[i] && slotRd[i] == MAX_REG_W'(sb.inIdRs2);
    assign allocVec[i] = allocEn && allocTag == TAG_W'(i);
    assign cplVec[i] = sb.inCplValid && sb.inCplTag == TAG_W'(i);
    load_use_scoreboard_slot #(.LOAD_LAT(LOAD_LAT), .VAR_LAT(VAR_LAT)) u_slot (
      .clk(clk),
      .reset(reset),
      .alloc(allocVec[i]),
      .allocRd(MAX_REG_W'(sb.inIdRd)),
      .cpl(cplVec[i]),
      .valid(slotValid[i]),
      .rd(slotRd[i])
    );
  end
  // hazards look only at registered entries: an entry freed this edge still stalls
  always_comb begin
    hazard = (sb.inIdUsesRs1 && sb.inIdRs1 != '0 && |hit1) || (sb.inIdUsesRs2 && sb.inIdRs2 != '0 && |hit2);
    full = &slotValid;
    stall = sb.inIdValid && (hazard || (sb.inIdIsLoad && full));
    allocTag = TAG_W'(first_free(32'(slotValid)));
    allocEn = sb.inIdValid && sb.inIdIsLoad && !stall && sb.inIdRd != '0;
  end
  always_ff @(posedge clk) begin
    if (reset) stallCount <= '0;
    else if (stall && !(&stallCount)) stallCount <= stallCount + 1'b1;
  end
  assign sb.outAllocTag = allocTag;
  assign sb.outPCWrite = !stall;
  assign sb.outIfIdWrite = !stall;
  assign sb.outCtrlMux = stall;
  assign sb.outFull = full;
  assign sb.outStallCount = stallCount;
endmodule

// File: tb/tb_load_use_scoreboard.sv
// tb_load_use_scoreboard: three scoreboard configurations driven in lockstep against a timeline model.
module tb_load_use_scoreboard;
  localparam int NK = 3;
  logic clk = 1'b0, rst = 1'b1;
  logic v = 1'b0, ld = 1'b0, u1 = 1'b0, u2 = 1'b0, cv = 1'b0;
  logic [4:0] rs1 = '0, rs2 = '0, rdI = '0;
  logic [1:0] ct = '0;
  logic [2:0] pcw, ifw, cm, full;
  logic [1:0] tagv [NK];
  logic [31:0] scnt [NK];
  int total = 0, bad = 0, cyc = 0, n;
  int nSl [NK] = '{4, 4, 2};
  int latK [NK] = '{1, 3, 1};
  bit varK [NK] = '{0, 0, 1};
  longint cmax [NK] = '{64'd4294967295, 64'd4294967295, 64'd15};
  bit mBusy [NK][4];
  int mRd [NK][4];
  int mFreeAt [NK][4];
  longint mCnt [NK];

  always #5 clk = ~clk;

  load_use_scoreboard_if #(.REG_W(5), .TAG_W(2), .CNT_W(32)) ifA ();
  load_use_scoreboard_if #(.REG_W(5), .TAG_W(2), .CNT_W(32)) ifB ();
  load_use_scoreboard_if #(.REG_W(5), .TAG_W(1), .CNT_W(4)) ifC ();
  load_use_scoreboard #(.NUM_SLOTS(4), .LOAD_LAT(1), .VAR_LAT(0), .CNT_W(32)) uA (.clk(clk), .reset(rst), .sb(ifA.slave));
  load_use_scoreboard #(.NUM_SLOTS(4), .LOAD_LAT(3), .VAR_LAT(0), .CNT_W(32)) uB (.clk(clk), .reset(rst), .sb(ifB.slave));
  load_use_scoreboard #(.NUM_SLOTS(2), .LOAD_LAT(1), .VAR_LAT(1), .CNT_W(4)) uC (.clk(clk), .reset(rst), .sb(ifC.slave));

  assign {ifA.inIdValid, ifA.inIdIsLoad, ifA.inIdUsesRs1, ifA.inIdUsesRs2, ifA.inCplValid} = {v, ld, u1, u2, cv};
  assign {ifB.inIdValid, ifB.inIdIsLoad, ifB.inIdUsesRs1, ifB.inIdUsesRs2, ifB.inCplValid} = {v, ld, u1, u2, cv};
  assign {ifC.inIdValid, ifC.inIdIsLoad, ifC.inIdUsesRs1, ifC.inIdUsesRs2, ifC.inCplValid} = {v, ld, u1, u2, cv};
  assign {ifA.inIdRs1, ifA.inIdRs2, ifA.inIdRd, ifA.inCplTag} = {rs1, rs2, rdI, ct};
  assign {ifB.inIdRs1, ifB.inIdRs2, ifB.inIdRd, ifB.inCplTag} = {rs1, rs2, rdI, ct};
  assign {ifC.inIdRs1, ifC.inIdRs2, ifC.inIdRd, ifC.inCplTag} = {rs1, rs2, rdI, ct[0]};
  assign pcw = {ifC.outPCWrite, ifB.outPCWrite, ifA.outPCWrite};
  assign ifw = {ifC.outIfIdWrite, ifB.outIfIdWrite, ifA.outIfIdWrite};
  assign cm = {ifC.outCtrlMux, ifB.outCtrlMux, ifA.outCtrlMux};
  assign full = {ifC.outFull, ifB.outFull, ifA.outFull};
  assign tagv[0] = ifA.outAllocTag;
  assign tagv[1] = ifB.outAllocTag;
  assign tagv[2] = {1'b0, ifC.outAllocTag};
  assign scnt[0] = ifA.outStallCount;
  assign scnt[1] = ifB.outStallCount;
  assign scnt[2] = 32'(ifC.outStallCount);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // a fixed-latency load allocated at the end of cycle t is pending in cycles t+1..t+LAT
  function automatic bit busy(int k, int s);
    return mBusy[k][s] && (varK[k] || cyc < mFreeAt[k][s]);
  endfunction
  function automatic bit pend(int k, int r);
    if (r == 0) return 1'b0;
    for (int s = 0; s < nSl[k]; s++) if (busy(k, s) && mRd[k][s] == r) return 1'b1;
    return 1'b0;
  endfunction
  function automatic bit isFull(int k);
    for (int s = 0; s < nSl[k]; s++) if (!busy(k, s)) return 1'b0;
    return 1'b1;
  endfunction
  function automatic int lowFree(int k);
    for (int s = 0; s < nSl[k]; s++) if (!busy(k, s)) return s;
    return 0;
  endfunction
  function automatic bit expStall(int k);
    return v && ((u1 && pend(k, int'(rs1))) || (u2 && pend(k, int'(rs2))) || (ld && isFull(k)));
  endfunction

  task automatic settle();
    #1;
    for (int k = 0; k < NK; k++) begin
      bit s = expStall(k);
      check($sformatf("k%0d_pcwrite", k), 32'(pcw[k]), 32'(!s));
      check($sformatf("k%0d_ifidwrite", k), 32'(ifw[k]), 32'(!s));
      check($sformatf("k%0d_ctrlmux", k), 32'(cm[k]), 32'(s));
      check($sformatf("k%0d_full", k), 32'(full[k]), 32'(isFull(k)));
      check($sformatf("k%0d_stallcount", k), scnt[k], 32'(mCnt[k]));
      if (!isFull(k)) check($sformatf("k%0d_alloctag", k), 32'(tagv[k]), 32'(lowFree(k)));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < NK; k++) begin
      bit st = expStall(k);
      bit al = v && ld && !st && rdI != 0;
      int t = lowFree(k);
      int tg = int'(ct) % nSl[k];
      if (rst) begin
        for (int s = 0; s < 4; s++) mBusy[k][s] = 1'b0;
        mCnt[k] = 0;
      end else begin
        if (st && mCnt[k] < cmax[k]) mCnt[k]++;
        if (varK[k] && cv && mBusy[k][tg]) mBusy[k][tg] = 1'b0;
        if (al) begin
          mBusy[k][t] = 1'b1;
          mRd[k][t] = int'(rdI);
          mFreeAt[k][t] = cyc + latK[k] + 1;
        end
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic drive(input logic iv, input logic il, input int ird, input logic iu1, input int ir1,
                       input logic iu2, input int ir2, input logic icv, input int ict);
    v = iv; ld = il; rdI = 5'(ird); u1 = iu1; rs1 = 5'(ir1); u2 = iu2; rs2 = 5'(ir2); cv = icv; ct = 2'(ict);
  endtask

  task automatic doReset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
  endtask

  // hold the current instruction until configuration k stops stalling
  task automatic holdStall(input int k, output int cnt);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      settle();
      if (!cm[k]) break;
      cnt++;
      tick();
    end
  endtask

  initial begin
    @(negedge clk);
    doReset();
    settle();
    check("rst_pcwrite", 32'(pcw[0]), 1);
    check("rst_ifidwrite", 32'(ifw[0]), 1);
    check("rst_ctrlmux", 32'(cm[0]), 0);
    check("rst_full", 32'(full[0]), 0);
    check("rst_count", scnt[0], 0);
    drive(1, 1, 5, 0, 0, 0, 0, 0, 0); settle(); tick();
    drive(1, 0, 0, 1, 5, 1, 7, 0, 0); holdStall(0, n); check("lat1_stalls", n, 1); tick();
    check("lat1_count", scnt[0], 1);
    doReset();
    drive(1, 1, 5, 0, 0, 0, 0, 0, 0); settle(); tick();
    drive(1, 0, 0, 1, 5, 1, 7, 0, 0); holdStall(1, n); check("lat3_b2b", n, 3); tick();
    doReset();
    drive(1, 1, 5, 0, 0, 0, 0, 0, 0); settle(); tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0); settle(); tick();
    drive(1, 0, 0, 1, 5, 1, 7, 0, 0); holdStall(1, n); check("lat3_gap", n, 2); tick();
    doReset();
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0); settle(); tick();
    drive(1, 0, 0, 1, 0, 1, 0, 0, 0); settle();
    check("x0_use", 32'(cm[0]), 0); check("x0_noalloc", 32'(tagv[0]), 0); tick();
    drive(1, 1, 5, 0, 0, 0, 0, 0, 0); settle(); tick();
    drive(1, 0, 0, 0, 5, 0, 5, 0, 0); settle(); check("unused_src", 32'(cm[0]), 0); tick();
    doReset();
    drive(1, 1, 1, 0, 0, 0, 0, 0, 0); settle(); check("var_tag0", 32'(tagv[2]), 0); tick();
    drive(1, 1, 2, 0, 0, 0, 0, 0, 0); settle(); check("var_tag1", 32'(tagv[2]), 1); tick();
    drive(1, 1, 3, 0, 0, 0, 0, 0, 0); settle();
    check("var_full", 32'(full[2]), 1); check("var_struct", 32'(cm[2]), 1); tick();
    drive(1, 1, 3, 0, 0, 0, 0, 1, 0); settle(); check("var_cplcycle", 32'(cm[2]), 1); tick();
    drive(1, 1, 3, 0, 0, 0, 0, 0, 0); settle();
    check("var_go", 32'(cm[2]), 0); check("var_retag", 32'(tagv[2]), 0); tick();
    doReset();
    drive(1, 1, 4, 0, 0, 0, 0, 0, 0); settle(); tick();
    drive(1, 1, 4, 0, 0, 0, 0, 0, 0); settle(); tick();
    drive(1, 0, 0, 1, 4, 0, 0, 1, 0); settle(); check("waw_stall", 32'(cm[2]), 1); tick();
    drive(1, 0, 0, 1, 4, 0, 0, 1, 0); settle(); check("waw_one_left", 32'(cm[2]), 1); tick();
    drive(1, 0, 0, 1, 4, 0, 0, 0, 0); settle();
    check("waw_inv_cpl", 32'(cm[2]), 1); check("waw_inv_tag", 32'(tagv[2]), 0); check("waw_inv_full", 32'(full[2]), 0);
    drive(1, 0, 0, 1, 4, 0, 0, 1, 1); settle(); check("waw_last_cyc", 32'(cm[2]), 1); tick();
    drive(1, 0, 0, 1, 4, 0, 0, 0, 0); settle(); check("waw_done", 32'(cm[2]), 0); tick();
    doReset();
    drive(1, 1, 1, 0, 0, 0, 0, 0, 0); settle(); tick();
    drive(1, 1, 2, 0, 0, 0, 0, 0, 0); settle(); tick();
    drive(1, 1, 3, 0, 0, 0, 0, 0, 0); settle(); tick();
    drive(1, 0, 0, 1, 1, 0, 0, 1, 0); settle(); check("pend3_tag", 32'(tagv[1]), 3);
    rst = 1'b1; tick(); rst = 1'b0;
    settle();
    check("midrst_full", 32'(full[1]), 0); check("midrst_stall", 32'(cm[1]), 0); check("midrst_count", scnt[1], 0);
    tick();
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 7),
            1'($urandom), $urandom_range(0, 7), 1'($urandom), $urandom_range(0, 7),
            $urandom_range(0, 2) == 0, $urandom_range(0, 3));
      settle();
      tick();
    end
    rst = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
